rca_adder: RTL and testbench
============================

RCA_ADDER -- requirements
Module: rca_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; it SHALL be at least 1.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 a  input  WIDTH  SHALL be operand A, unsigned.
REQ-005 b  input  WIDTH  SHALL be operand B, unsigned.
REQ-006 cin  input  1  SHALL be the carry-in.
REQ-007 sum  output  WIDTH+1  SHALL be the registered result; MSB is carry-out.

Function
REQ-008 a, b and cin SHALL be captured into input registers a_q, b_q, cin_q on each rising clk edge while rst is high.
REQ-009 The adder SHALL be a ripple-carry chain of WIDTH full adders fed from a_q, b_q, cin_q.
REQ-010 Stage 0 carry-in SHALL be cin_q, and each stage i+1 SHALL take the carry-out of stage i.
REQ-011 Each stage SHALL compute s = x^y^c and co = (x&y)|(c&(x^y)).
REQ-012 The chain result {carry-out of stage WIDTH-1, s[WIDTH-1:0]} SHALL be registered into sum on the next rising edge.
REQ-013 Latency SHALL be 2 clock edges: operands sampled at edge N appear on sum after edge N+1.
REQ-014 Throughput SHALL be one new operand set per cycle, with no handshake and no stall.
REQ-015 Arithmetic SHALL be unsigned and exact, with no saturation or wrap-around.
REQ-016 Maximum sum SHALL be 2^(WIDTH+1)-1 (for WIDTH=4, 15+15+1 = 31 = 5'b11111).
REQ-017 Input changes between clock edges SHALL NOT affect sum until they are sampled.
REQ-018 sum SHALL be glitch-free between edges because it is driven directly from flops.
REQ-019 The design SHALL be synthesizable.
REQ-020 The design SHALL be clean under SDF back-annotated gate-level simulation at a 5 ns clock period.

Reset
REQ-021 When rst goes low, a_q, b_q, cin_q and sum SHALL clear to 0 immediately, without waiting for clk.
REQ-022 While rst is low, sum SHALL hold 0 and inputs SHALL be ignored.
REQ-023 On the first rising edge after rst goes high, inputs SHALL be sampled, and sum SHALL still read 0 until the following edge.
REQ-024 If rst is asserted mid-operation, in-flight results SHALL be discarded, with no partial result emitted after release.

Structure
REQ-025 A shared package rca_pkg SHALL hold the default WIDTH constant (4) and a typedef for the WIDTH+1 result vector.
REQ-026 One sub-module, full_adder (ports x, y, c, s, co), SHALL be defined.
REQ-027 full_adder SHALL be instantiated WIDTH times through a generate loop.
REQ-028 Top-level rca_adder SHALL contain only the input registers, the carry chain wiring and the output register.

Verification
REQ-029 Hold rst=0 for 20 ns with a=0, b=1, cin=0 -> sum=5'b00000 throughout.
REQ-030 Release rst, then apply a=7, b=1, cin=0 -> sum=5'b01000 two edges after sampling.
REQ-031 Apply a=1, b=5, cin=0, then a=2, b=5, cin=0 on consecutive cycles -> sum=6, then sum=7, one per cycle.
REQ-032 Apply a=15, b=15, cin=1 -> sum=31; apply a=15, b=0, cin=1 -> sum=16, with the full carry ripple through every stage.
REQ-033 Assert rst asynchronously mid-cycle while sum is nonzero -> sum=0 immediately, before any clock edge.
REQ-034 Exhaustively sweep all a, b, cin for WIDTH=4 against a+b+cin delayed by 2 cycles -> no mismatches.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry adder.
package rca_pkg;

    // Default operand width in bits.
    localparam int unsigned RCA_WIDTH = 4;

    // Result vector for the default width: carry-out in the MSB.
    typedef logic [RCA_WIDTH:0] rca_sum_t;

endpackage : rca_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the carry chain.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and carry outputs.
    always_comb begin
        p  = x ^ y;
        s  = p ^ c;
        co = (x & y) | (c & p);
    end

endmodule : full_adder

// File: rtl/rca_adder.sv
// Registered ripple-carry adder: input registers, a WIDTH-stage carry chain,
// and an output register. Two-edge latency, one operand set per cycle.
module rca_adder
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic             cin_d, cin_q;
    logic [WIDTH:0]   sum_d, sum_q;

    logic [WIDTH-1:0] s_chain;
    // carry[i] feeds stage i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;

    // Next-state for the input and output registers.
    always_comb begin
        a_d   = a;
        b_d   = b;
        cin_d = cin;
        sum_d = {carry[WIDTH], s_chain};
    end

    // Pipeline registers, cleared asynchronously so in-flight results are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            sum_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
            sum_q <= sum_d;
        end
    end

    assign carry[0] = cin_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .x  (a_q[i]),
            .y  (b_q[i]),
            .c  (carry[i]),
            .s  (s_chain[i]),
            .co (carry[i+1])
        );
    end

    // Output comes straight from flops so it cannot glitch between edges.
    assign sum = sum_q;

endmodule : rca_adder

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder: directed cases, reset behaviour,
// exhaustive 4-bit sweep and random traffic against an arithmetic model.
module tb_rca_adder;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   sum;

    int n_checks;
    int n_errors;
    // Model: value that should appear on sum after the next rising edge.
    int pend;

    rca_adder #(
        .WIDTH (W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle starting at a falling edge: junk first, then the real operands,
    // then check the result of the previously sampled set after the rising edge.
    task automatic cyc(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc);
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        #2;
        a   = ta;
        b   = tb;
        cin = tc;
        @(posedge clk);
        #1;
        check_eq(tag, int'(sum), pend);
        pend = int'(ta) + int'(tb) + int'(tc);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pend     = 0;
        a        = '0;
        b        = 4'd1;
        cin      = 1'b0;
        rst      = 1'b1;
        #1;
        rst      = 1'b0;
        #1;
        check_eq("reset_async", int'(sum), 0);

        // Hold reset across several edges; inputs must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("reset_hold", int'(sum), 0);
        end
        @(negedge clk);
        rst  = 1'b1;
        pend = 0;

        // First edge after release still shows 0, then 7+1.
        cyc("first_after_rel", 4'd7, 4'd1, 1'b0);
        cyc("seven_plus_one", 4'd1, 4'd5, 1'b0);
        check_eq("const_8", int'(sum), 8);
        cyc("one_plus_five", 4'd2, 4'd5, 1'b0);
        check_eq("const_6", int'(sum), 6);
        cyc("two_plus_five", 4'd15, 4'd15, 1'b1);
        check_eq("const_7", int'(sum), 7);
        cyc("max_sum", 4'd15, 4'd0, 1'b1);
        check_eq("const_31", int'(sum), 31);
        cyc("full_ripple", 4'd9, 4'd9, 1'b0);
        check_eq("const_16", int'(sum), 16);

        // Asynchronous reset mid-cycle while the output is nonzero.
        #2;
        check_eq("pre_rst_nonzero", int'(sum != '0), 1);
        rst = 1'b0;
        #1;
        check_eq("mid_cycle_rst", int'(sum), 0);
        a   = 4'd15;
        b   = 4'd15;
        cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_ignores_in", int'(sum), 0);
        end
        @(negedge clk);
        rst  = 1'b1;
        pend = 0;
        // No stale result may escape after release.
        cyc("no_stale_out", 4'd3, 4'd4, 1'b1);
        cyc("after_rst_sum", 4'd0, 4'd0, 1'b0);
        check_eq("const_after_rst", int'(sum), 8);

        // Exhaustive sweep of every operand combination.
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    cyc("sweep", W'(ia), W'(ib), 1'(ci));
                end
            end
        end

        // Random back-to-back traffic.
        for (int i = 0; i < 200; i++) begin
            cyc("random", W'($urandom), W'($urandom), 1'($urandom));
        end
        cyc("drain", 4'd0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rca_adder
